// File: rtl/k_lpf_multichannel_if.sv
// Sample/clear request and filtered-output bundle of the multichannel low-pass filter.
// The master side drives samples and clears. The slave side returns filtered samples.
interface k_lpf_multichannel_if #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned CHANNELS = 40
);
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                     in_valid;
    logic [CH_W-1:0]          in_ch;
    logic signed [DATA_W-1:0] x;
    logic [5:0]               k_cfg;
    logic                     bypass;
    logic                     clr;
    logic [CH_W-1:0]          clr_ch;

    logic                     out_valid;
    logic [CH_W-1:0]          out_ch;
    logic signed [DATA_W-1:0] y;
    logic                     sat;

    modport master (
        output in_valid, in_ch, x, k_cfg, bypass, clr, clr_ch,
        input  out_valid, out_ch, y, sat
    );

    modport slave (
        input  in_valid, in_ch, x, k_cfg, bypass, clr, clr_ch,
        output out_valid, out_ch, y, sat
    );
endinterface

// File: rtl/k_lpf_multichannel.sv
// Time-multiplexed first-order IIR low-pass filter shared by up to CHANNELS channels.
// Pipeline: capture -> state read/compute/write -> registered output (latency 2, one sample/clk).
module k_lpf_multichannel #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FRAC_W    = 32,
    parameter int unsigned CHANNELS  = 40,
    parameter int unsigned K_DEFAULT = 26
) (
    input logic                  clk,
    input logic                  reset_n,
    k_lpf_multichannel_if.slave  bus
);
    localparam int unsigned ACC_W = DATA_W + FRAC_W + 2;
    localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned CHX_W = CH_W + 1;
    localparam int unsigned K_W   = 6;
    localparam int unsigned Y_LSB = FRAC_W;
    localparam int unsigned Y_MSB = FRAC_W + DATA_W - 1;

    logic                     accept;
    logic                     clr_all;
    logic [K_W-1:0]           k_eff;

    logic                     s0_valid;
    logic [CH_W-1:0]          s0_ch;
    logic signed [DATA_W-1:0] s0_x;
    logic [K_W-1:0]           s0_k;
    logic                     s0_byp;

    logic signed [ACC_W-1:0]  acc_q [CHANNELS];
    logic signed [DATA_W-1:0] xp_q  [CHANNELS];

    logic signed [ACC_W-1:0]  acc_rd;
    logic signed [ACC_W-1:0]  x_ext;
    logic signed [ACC_W-1:0]  xp_ext;
    logic signed [ACC_W-1:0]  w;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic [ACC_W-1:Y_MSB]     acc_hi;
    logic signed [DATA_W-1:0] y_nxt;
    logic                     sat_nxt;

    logic                     out_valid_q;
    logic [CH_W-1:0]          out_ch_q;
    logic signed [DATA_W-1:0] y_q;
    logic                     sat_q;

    // Out-of-range channels are dropped; out-of-range clear targets mean "all channels".
    assign accept  = bus.in_valid && ({1'b0, bus.in_ch} < CHX_W'(CHANNELS));
    assign clr_all = ({1'b0, bus.clr_ch} >= CHX_W'(CHANNELS));

    // k_cfg of 0 selects the default; result clamped to [2, FRAC_W].
    always_comb begin
        k_eff = (bus.k_cfg == '0) ? K_W'(K_DEFAULT) : bus.k_cfg;
        if (k_eff < K_W'(2)) begin
            k_eff = K_W'(2);
        end else if (k_eff > K_W'(FRAC_W)) begin
            k_eff = K_W'(FRAC_W);
        end
    end

    // Stage 0: capture the accepted sample and its per-sample controls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_valid <= 1'b0;
            s0_ch    <= '0;
            s0_x     <= '0;
            s0_k     <= K_W'(2);
            s0_byp   <= 1'b0;
        end else begin
            s0_valid <= accept;
            if (accept) begin
                s0_ch  <= bus.in_ch;
                s0_x   <= bus.x;
                s0_k   <= k_eff;
                s0_byp <= bus.bypass;
            end
        end
    end

    // Stage 1: state is written at the same edge the next sample enters stage 0, so reads are never stale.
    always_comb begin
        acc_rd = acc_q[s0_ch];
        x_ext  = ACC_W'(s0_x) <<< FRAC_W;
        xp_ext = ACC_W'(xp_q[s0_ch]) <<< FRAC_W;
        w      = x_ext + xp_ext;
        if (s0_byp) begin
            acc_nxt = x_ext;
        end else begin
            acc_nxt = acc_rd + (w >>> s0_k) - (acc_rd >>> (s0_k - K_W'(1)));
        end
    end

    // Integer part of the accumulator, clipped to the output range.
    always_comb begin
        acc_hi  = acc_nxt[ACC_W-1:Y_MSB];
        sat_nxt = 1'b0;
        y_nxt   = acc_nxt[Y_MSB:Y_LSB];
        if (s0_byp) begin
            y_nxt = s0_x;
        end else if (!(&acc_hi) && (|acc_hi)) begin
            sat_nxt = 1'b1;
            y_nxt   = acc_nxt[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                       : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    // Per-channel state; a clear at the same edge as a write takes priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                acc_q[i] <= '0;
                xp_q[i]  <= '0;
            end
        end else begin
            if (s0_valid) begin
                acc_q[s0_ch] <= acc_nxt;
                xp_q[s0_ch]  <= s0_x;
            end
            if (bus.clr) begin
                if (clr_all) begin
                    for (int i = 0; i < int'(CHANNELS); i++) begin
                        acc_q[i] <= '0;
                        xp_q[i]  <= '0;
                    end
                end else begin
                    acc_q[bus.clr_ch] <= '0;
                    xp_q[bus.clr_ch]  <= '0;
                end
            end
        end
    end

    // Stage 2: output register; data holds while no sample completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            y_q         <= '0;
            sat_q       <= 1'b0;
        end else begin
            out_valid_q <= s0_valid;
            if (s0_valid) begin
                out_ch_q <= s0_ch;
                y_q      <= y_nxt;
                sat_q    <= sat_nxt;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.y         = y_q;
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_k_lpf_multichannel.sv
// Bench for k_lpf_multichannel: directed scenarios plus random traffic against an exact fixed-point reference.
module tb_k_lpf_multichannel;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned FRAC_W    = 32;
    localparam int unsigned CHANNELS  = 40;
    localparam int unsigned K_DEFAULT = 26;
    localparam longint      ONE       = longint'(1) << FRAC_W;

    logic clk = 1'b0;
    logic reset_n;
    int   tests_run = 0;
    int   fails = 0;

    k_lpf_multichannel_if #(.DATA_W(DATA_W), .CHANNELS(CHANNELS)) bus ();

    k_lpf_multichannel #(
        .DATA_W(DATA_W), .FRAC_W(FRAC_W), .CHANNELS(CHANNELS), .K_DEFAULT(K_DEFAULT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: exact accumulator value in units of 2^-FRAC_W.
    longint             m_acc [CHANNELS];
    int                 m_xp  [CHANNELS];
    logic               p_v;
    int                 p_ch, p_x, p_k;
    logic               p_byp;
    logic               exp_valid, exp_sat;
    logic [5:0]         exp_ch;
    logic signed [15:0] exp_y;
    logic               obs_valid, obs_sat;
    logic [5:0]         obs_ch;
    logic signed [15:0] obs_y;

    // floor(a / 2^sh)
    function automatic longint fdiv(input longint a, input int sh);
        longint d, q;
        d = longint'(1) << sh;
        q = a / d;
        if (a < 0 && (a % d) != 0) q = q - 1;
        return q;
    endfunction

    function automatic int keff(input int kc);
        int k;
        k = (kc == 0) ? int'(K_DEFAULT) : kc;
        if (k < 2) k = 2;
        if (k > int'(FRAC_W)) k = int'(FRAC_W);
        return k;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(CHANNELS); i++) begin
            m_acc[i] = 0;
            m_xp[i]  = 0;
        end
        p_v = 1'b0; p_ch = 0; p_x = 0; p_k = 2; p_byp = 1'b0;
        exp_valid = 1'b0; exp_ch = '0; exp_y = '0; exp_sat = 1'b0;
    endtask

    // One clock edge: finish the sample captured last edge, apply the clear, capture the new sample.
    task automatic model_edge(input logic v, input int ch, input int x, input int kc,
                              input logic byp, input logic c, input int cch);
        longint a, nw, yl;
        exp_valid = p_v;
        if (p_v) begin
            if (p_byp) begin
                nw = longint'(p_x) * ONE;
                yl = p_x;
            end else begin
                a  = m_acc[p_ch];
                nw = a + fdiv(longint'(p_x + m_xp[p_ch]) * ONE, p_k) - fdiv(a, p_k - 1);
                yl = fdiv(nw, int'(FRAC_W));
            end
            if (yl > 64'sd32767) begin
                exp_y = 16'sh7fff; exp_sat = 1'b1;
            end else if (yl < -64'sd32768) begin
                exp_y = 16'sh8000; exp_sat = 1'b1;
            end else begin
                exp_y = 16'(yl); exp_sat = 1'b0;
            end
            exp_ch = 6'(p_ch);
            m_acc[p_ch] = nw;
            m_xp[p_ch]  = p_x;
        end
        if (c) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                if (cch >= int'(CHANNELS) || cch == i) begin
                    m_acc[i] = 0;
                    m_xp[i]  = 0;
                end
            end
        end
        p_v = v && (ch < int'(CHANNELS));
        if (p_v) begin
            p_ch = ch; p_x = x; p_k = keff(kc); p_byp = byp;
        end
    endtask

    task automatic step(input logic v, input int ch, input int x, input int kc,
                        input logic byp, input logic c, input int cch);
        bus.in_valid = v;
        bus.in_ch    = 6'(ch);
        bus.x        = 16'(x);
        bus.k_cfg    = 6'(kc);
        bus.bypass   = byp;
        bus.clr      = c;
        bus.clr_ch   = 6'(cch);
        @(posedge clk);
        model_edge(v, ch, x, kc, byp, c, cch);
        #1;
        obs_valid = bus.out_valid;
        obs_ch    = bus.out_ch;
        obs_y     = bus.y;
        obs_sat   = bus.sat;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        obs_valid = bus.out_valid; obs_ch = bus.out_ch; obs_y = bus.y; obs_sat = bus.sat;
        tests_run++;
        if ({obs_valid, obs_ch, obs_y, obs_sat} !== {exp_valid, exp_ch, exp_y, exp_sat}) begin
            fails++;
            $display("FAIL reset: got v=%b ch=%0d y=%0d sat=%b, expected v=%b ch=%0d y=%0d sat=%b",
                     obs_valid, obs_ch, obs_y, obs_sat, exp_valid, exp_ch, exp_y, exp_sat);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_step_response();
        logic signed [15:0] ys[$];
        for (int i = 0; i < 6; i++) begin
            step(i < 3, 3, 1000, 4, 1'b0, 1'b0, 0);
            tests_run++;
            if ({obs_valid, obs_ch, obs_y, obs_sat} !== {exp_valid, exp_ch, exp_y, exp_sat}) begin
                fails++;
                $display("FAIL step_resp[%0d]: got v=%b ch=%0d y=%0d sat=%b, expected v=%b ch=%0d y=%0d sat=%b",
                         i, obs_valid, obs_ch, obs_y, obs_sat, exp_valid, exp_ch, exp_y, exp_sat);
            end
            if (obs_valid) ys.push_back(obs_y);
        end
        tests_run++;
        if (ys.size() != 3 || ys[0] !== 16'sd62 || ys[1] !== 16'sd179) begin
            fails++;
            $display("FAIL step_resp_values: got %0d outputs first=%0d second=%0d, expected 3 outputs 62 179",
                     ys.size(), (ys.size() > 0) ? ys[0] : 16'sd0, (ys.size() > 1) ? ys[1] : 16'sd0);
        end
    endtask

    task automatic test_negative();
        logic signed [15:0] first, last;
        int nout;
        nout = 0; first = '0; last = '0;
        for (int i = 0; i < 82; i++) begin
            step(i < 80, 4, -1000, 4, 1'b0, 1'b0, 0);
            tests_run++;
            if ({obs_valid, obs_ch, obs_y, obs_sat} !== {exp_valid, exp_ch, exp_y, exp_sat}) begin
                fails++;
                $display("FAIL negative[%0d]: got v=%b ch=%0d y=%0d sat=%b, expected v=%b ch=%0d y=%0d sat=%b",
                         i, obs_valid, obs_ch, obs_y, obs_sat, exp_valid, exp_ch, exp_y, exp_sat);
            end
            if (obs_valid) begin
                if (nout == 0) first = obs_y;
                last = obs_y;
                nout++;
            end
        end
        tests_run++;
        if (first !== -16'sd63 || last < -16'sd1001 || last > -16'sd999) begin
            fails++;
            $display("FAIL negative_values: got first=%0d last=%0d, expected first=-63 last in [-1001,-999]",
                     first, last);
        end
    endtask

    task automatic test_interleave();
        logic signed [15:0] y0[$];
        logic signed [15:0] y1[$];
        int bad1;
        step(1'b0, 0, 0, 0, 1'b0, 1'b1, 63);
        for (int i = 0; i < 10; i++) begin
            step(i < 8, i % 2, (i % 2 == 0) ? 1000 : 0, 4, 1'b0, 1'b0, 0);
            tests_run++;
            if ({obs_valid, obs_ch, obs_y, obs_sat} !== {exp_valid, exp_ch, exp_y, exp_sat}) begin
                fails++;
                $display("FAIL interleave[%0d]: got v=%b ch=%0d y=%0d sat=%b, expected v=%b ch=%0d y=%0d sat=%b",
                         i, obs_valid, obs_ch, obs_y, obs_sat, exp_valid, exp_ch, exp_y, exp_sat);
            end
            if (obs_valid && obs_ch == 6'd0) y0.push_back(obs_y);
            if (obs_valid && obs_ch == 6'd1) y1.push_back(obs_y);
        end
        bad1 = 0;
        foreach (y1[j]) if (y1[j] !== 16'sd0) bad1++;
        tests_run++;
        if (y0.size() != 4 || y1.size() != 4 || y0[0] !== 16'sd62 || y0[1] !== 16'sd179 || bad1 != 0) begin
            fails++;
            $display("FAIL interleave_values: got ch0 n=%0d ch1 n=%0d ch1 nonzero=%0d, expected 4/4 ch0 62,179 ch1 all 0",
                     y0.size(), y1.size(), bad1);
        end
    endtask

    task automatic test_back_to_back();
        int xs[8];
        int kc;
        logic signed [15:0] q1[$];
        logic signed [15:0] q2[$];
        kc = int'($urandom_range(2, 8));
        for (int i = 0; i < 8; i++) xs[i] = int'($urandom_range(0, 40000)) - 20000;
        step(1'b0, 0, 0, 0, 1'b0, 1'b1, 5);
        for (int pass = 0; pass < 2; pass++) begin
            int gap, n;
            gap = (pass == 0) ? 1 : 4;
            n   = 8 * gap + 2;
            for (int i = 0; i < n; i++) begin
                logic v;
                v = (i % gap == 0) && (i / gap < 8);
                step(v, 5, v ? xs[i / gap] : 0, kc, 1'b0, 1'b0, 0);
                tests_run++;
                if ({obs_valid, obs_ch, obs_y, obs_sat} !== {exp_valid, exp_ch, exp_y, exp_sat}) begin
                    fails++;
                    $display("FAIL back_to_back[p%0d,%0d]: got v=%b ch=%0d y=%0d sat=%b, expected v=%b ch=%0d y=%0d sat=%b",
                             pass, i, obs_valid, obs_ch, obs_y, obs_sat, exp_valid, exp_ch, exp_y, exp_sat);
                end
                if (obs_valid) begin
                    if (pass == 0) q1.push_back(obs_y);
                    else q2.push_back(obs_y);
                end
            end
            if (pass == 0) step(1'b0, 0, 0, 0, 1'b0, 1'b1, 5);
        end
        tests_run++;
        if (q1.size() != 8 || q2.size() != 8 || q1 != q2) begin
            fails++;
            $display("FAIL back_to_back_equal: got n1=%0d n2=%0d differing sequences, expected 8 identical outputs",
                     q1.size(), q2.size());
        end
    endtask

    task automatic test_saturation();
        step(1'b0, 0, 0, 0, 1'b0, 1'b1, 2);
        for (int i = 0; i < 18; i++) begin
            step(i < 16, 2, (i % 2 == 0) ? 32767 : -32768, 2, 1'b0, 1'b0, 0);
            tests_run++;
            if ({obs_valid, obs_ch, obs_y, obs_sat} !== {exp_valid, exp_ch, exp_y, exp_sat}) begin
                fails++;
                $display("FAIL saturation[%0d]: got v=%b ch=%0d y=%0d sat=%b, expected v=%b ch=%0d y=%0d sat=%b",
                         i, obs_valid, obs_ch, obs_y, obs_sat, exp_valid, exp_ch, exp_y, exp_sat);
            end
        end
    endtask

    task automatic test_bypass_clear();
        int tv[7], tb_[7], tc[7], chk[7];
        tv  = '{1, 0, 1, 0, 1, 1, 0};
        tb_ = '{1, 0, 0, 0, 0, 0, 0};
        tc  = '{0, 0, 0, 0, 0, 1, 0};
        chk = '{-1, 500, -1, 500, -1, 500, 31};
        step(1'b0, 0, 0, 0, 1'b0, 1'b1, 7);
        for (int i = 0; i < 82; i++) begin
            step(i < 80, 7, 1000, 4, 1'b0, 1'b0, 0);
            tests_run++;
            if ({obs_valid, obs_ch, obs_y, obs_sat} !== {exp_valid, exp_ch, exp_y, exp_sat}) begin
                fails++;
                $display("FAIL converge[%0d]: got v=%b ch=%0d y=%0d sat=%b, expected v=%b ch=%0d y=%0d sat=%b",
                         i, obs_valid, obs_ch, obs_y, obs_sat, exp_valid, exp_ch, exp_y, exp_sat);
            end
        end
        for (int i = 0; i < 7; i++) begin
            step(tv[i] != 0, 7, 500, 4, tb_[i] != 0, tc[i] != 0, 7);
            tests_run++;
            if ({obs_valid, obs_ch, obs_y, obs_sat} !== {exp_valid, exp_ch, exp_y, exp_sat}) begin
                fails++;
                $display("FAIL bypass_clear[%0d]: got v=%b ch=%0d y=%0d sat=%b, expected v=%b ch=%0d y=%0d sat=%b",
                         i, obs_valid, obs_ch, obs_y, obs_sat, exp_valid, exp_ch, exp_y, exp_sat);
            end
            if (chk[i] >= 0) begin
                tests_run++;
                if (obs_valid !== 1'b1 || obs_y !== 16'(chk[i])) begin
                    fails++;
                    $display("FAIL bypass_clear_value[%0d]: got v=%b y=%0d, expected v=1 y=%0d",
                             i, obs_valid, obs_y, chk[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            int ch, kc;
            ch = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63));
            kc = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 63));
            step($urandom_range(0, 9) < 8, ch, int'($urandom_range(0, 65535)) - 32768, kc,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0, int'($urandom_range(0, 63)));
            tests_run++;
            if ({obs_valid, obs_ch, obs_y, obs_sat} !== {exp_valid, exp_ch, exp_y, exp_sat}) begin
                fails++;
                $display("FAIL random[%0d]: got v=%b ch=%0d y=%0d sat=%b, expected v=%b ch=%0d y=%0d sat=%b",
                         i, obs_valid, obs_ch, obs_y, obs_sat, exp_valid, exp_ch, exp_y, exp_sat);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 9, 1234, 3, 1'b0, 1'b0, 0);
        bus.in_valid = 1'b0; bus.clr = 1'b0;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        obs_valid = bus.out_valid; obs_ch = bus.out_ch; obs_y = bus.y; obs_sat = bus.sat;
        tests_run++;
        if ({obs_valid, obs_ch, obs_y, obs_sat} !== {exp_valid, exp_ch, exp_y, exp_sat}) begin
            fails++;
            $display("FAIL async_reset: got v=%b ch=%0d y=%0d sat=%b, expected v=%b ch=%0d y=%0d sat=%b",
                     obs_valid, obs_ch, obs_y, obs_sat, exp_valid, exp_ch, exp_y, exp_sat);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(i == 2, 9, 1000, 4, 1'b0, 1'b0, 0);
            tests_run++;
            if ({obs_valid, obs_ch, obs_y, obs_sat} !== {exp_valid, exp_ch, exp_y, exp_sat}) begin
                fails++;
                $display("FAIL after_reset[%0d]: got v=%b ch=%0d y=%0d sat=%b, expected v=%b ch=%0d y=%0d sat=%b",
                         i, obs_valid, obs_ch, obs_y, obs_sat, exp_valid, exp_ch, exp_y, exp_sat);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b1;
        bus.in_valid = 1'b0; bus.in_ch = '0; bus.x = '0; bus.k_cfg = '0;
        bus.bypass = 1'b0; bus.clr = 1'b0; bus.clr_ch = '0;
        model_reset();
        #2 reset_n = 1'b0;
        test_reset();
        test_step_response();
        test_negative();
        test_interleave();
        test_back_to_back();
        test_saturation();
        test_bypass_clear();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
